thor2024_fc_tracker: RTL

- Backend consumer of the decode-stage flow-control flag (fc).
- Holds every in-flight flow-control instruction (SYS, JSR, Bcc, BBC/BBS, RTD) in program order, with its ROB tag and predicted target.
- Accepts out-of-order resolutions from the branch unit and retires entries in order.
- On a target mismatch at retirement, issues a single redirect to fetch and flushes all younger tracked entries.

---
 rtl/thor2024_fc_tracker.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/thor2024_fc_tracker.sv
// -----------------------------------------------------------------------------
// thor2024_fc_tracker
//
// Purpose:
//   Tracks every in-flight flow-control instruction (SYS, JSR, Bcc, BBC/BBS,
//   RTD) in program order. Each entry holds the ROB tag and the predicted next
//   PC. The branch unit resolves entries out of order; entries retire in order
//   from the head. A retiring entry whose actual target differs from its
//   prediction raises a single redirect to fetch and flushes all younger
//   tracked entries.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   alloc_v      in   decode slot valid
//   alloc_fc     in   decoded flow-control flag for the slot
//   alloc_rob    in   ROB tag of the slot                  [ROBW]
//   alloc_pred   in   predicted next PC of the slot        [PCW]
//   alloc_rdy    out  tracker can accept an allocation (registered)
//   alloc_idx    out  entry index given to an allocation   [IDXW]
//   res_v        in   branch unit resolution valid
//   res_idx      in   entry being resolved                 [IDXW]
//   res_tgt      in   actual next PC                       [PCW]
//   retire_v     out  one-cycle pulse: head entry retired
//   retire_rob   out  ROB tag of the retired entry         [ROBW]
//   redirect_v   out  one-cycle pulse: mispredict at retire
//   redirect_pc  out  correct fetch PC                     [PCW]
//   count        out  number of occupied entries           [IDXW+1]
// -----------------------------------------------------------------------------
module thor2024_fc_tracker #(
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH),
  parameter int ROBW  = 6,
  parameter int PCW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_v,
  input  logic            alloc_fc,
  input  logic [ROBW-1:0] alloc_rob,
  input  logic [PCW-1:0]  alloc_pred,
  output logic            alloc_rdy,
  output logic [IDXW-1:0] alloc_idx,
  input  logic            res_v,
  input  logic [IDXW-1:0] res_idx,
  input  logic [PCW-1:0]  res_tgt,
  output logic            retire_v,
  output logic [ROBW-1:0] retire_rob,
  output logic            redirect_v,
  output logic [PCW-1:0]  redirect_pc,
  output logic [IDXW:0]   count
);

  localparam logic [IDXW:0] DEPTH_C = (IDXW+1)'(DEPTH);

  // Control state
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_resolved;
  logic [IDXW-1:0]  r_head;
  logic [IDXW-1:0]  r_tail;
  logic [IDXW:0]    r_count;
  logic             r_alloc_rdy;
  logic             r_retire_v;
  logic [ROBW-1:0]  r_retire_rob;
  logic             r_redirect_v;
  logic [PCW-1:0]   r_redirect_pc;

  // Entry payload; meaningful only while the matching valid/resolved bit is set
  logic [ROBW-1:0]  r_rob  [DEPTH];
  logic [PCW-1:0]   r_pred [DEPTH];
  logic [PCW-1:0]   r_act  [DEPTH];

  logic             w_retire;
  logic             w_mispred;
  logic             w_alloc_acc;
  logic             w_res_acc;
  logic [IDXW-1:0]  w_head_inc;
  logic [IDXW-1:0]  w_tail_inc;
  logic [IDXW:0]    w_count_next;
  logic [DEPTH-1:0] w_valid_next;
  logic [DEPTH-1:0] w_resolved_next;

  // Retire decision looks only at the registered head entry
  assign w_retire   = r_valid[r_head] && r_resolved[r_head];
  assign w_mispred  = w_retire && (r_act[r_head] != r_pred[r_head]);
  assign w_head_inc = r_head + 1'b1;
  assign w_tail_inc = r_tail + 1'b1;

  // Anything presented on the flush cycle belongs to the wrong path
  assign w_alloc_acc = alloc_v && alloc_fc && r_alloc_rdy && !w_mispred;
  assign w_res_acc   = res_v && r_valid[res_idx] && !r_resolved[res_idx] &&
                       !w_mispred;

  always_comb begin
    w_valid_next    = r_valid;
    w_resolved_next = r_resolved;
    w_count_next    = r_count + (IDXW+1)'(w_alloc_acc) - (IDXW+1)'(w_retire);
    if (w_retire) begin
      w_valid_next[r_head]    = 1'b0;
      w_resolved_next[r_head] = 1'b0;
    end
    if (w_res_acc) begin
      w_resolved_next[res_idx] = 1'b1;
    end
    if (w_alloc_acc) begin
      w_valid_next[r_tail]    = 1'b1;
      w_resolved_next[r_tail] = 1'b0;
    end
    if (w_mispred) begin
      w_valid_next    = '0;
      w_resolved_next = '0;
      w_count_next    = '0;
    end
  end

  // Control registers: pointers, occupancy, per-entry flags, output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= '0;
      r_resolved    <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_alloc_rdy   <= 1'b1;
      r_retire_v    <= 1'b0;
      r_retire_rob  <= '0;
      r_redirect_v  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_valid      <= w_valid_next;
      r_resolved   <= w_resolved_next;
      r_count      <= w_count_next;
      // Ready follows the count of the previous edge, so leaving the full
      // state costs one bubble; the second term blocks an overfill.
      r_alloc_rdy  <= (r_count != DEPTH_C) && (w_count_next != DEPTH_C);
      r_retire_v   <= w_retire;
      r_redirect_v <= w_mispred;
      if (w_retire) begin
        r_head       <= w_head_inc;
        r_retire_rob <= r_rob[r_head];
      end
      if (w_mispred) begin
        r_tail        <= w_head_inc;
        r_redirect_pc <= r_act[r_head];
      end else if (w_alloc_acc) begin
        r_tail <= w_tail_inc;
      end
    end
  end

  // Payload registers: written without reset, qualified by the control flags
  always_ff @(posedge clk) begin
    if (w_alloc_acc) begin
      r_rob[r_tail]  <= alloc_rob;
      r_pred[r_tail] <= alloc_pred;
    end
    if (w_res_acc) begin
      r_act[res_idx] <= res_tgt;
    end
  end

  assign alloc_rdy   = r_alloc_rdy;
  assign alloc_idx   = r_tail;
  assign retire_v    = r_retire_v;
  assign retire_rob  = r_retire_rob;
  assign redirect_v  = r_redirect_v;
  assign redirect_pc = r_redirect_pc;
  assign count       = r_count;

endmodule
